data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, gives the data RAM size in 32-bit words.
REQ-002 Parameter CLKS_PER_BIT, default 16, gives the clock cycles per UART bit (minimum 2).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 daddr  input  32  byte address from the core MEM stage.
REQ-006 ddata_w  input  32  store data.
REQ-007 d_w  input  1  store strobe, one cycle per store.
REQ-008 d_r  input  1  load strobe, one cycle per load.
REQ-009 ddata_r  output  32  load data, combinational from daddr in the same cycle.
REQ-010 gpio_out  output  8  GPIO register value.
REQ-011 tx_o  output  1  UART serial output, idle high.

Function
REQ-012 Address decode:
- RAM: daddr < DEPTH_WORDS*4.
- MMIO: 0xFFFF0000 GPIO (R/W, bits 7:0), 0xFFFF0004 CYCLE (RO; any write clears it), 0xFFFF0008 TXDATA (WO; reads return 0), 0xFFFF000C STATUS (RO; any write clears ERR).
- Every other address is unmapped.
REQ-013 Accesses are word-only; daddr[1:0] != 0 makes the access misaligned.
REQ-014 RAM read is asynchronous: ddata_r = mem[daddr[31:2]] whenever d_r=1 and the address is a mapped, aligned RAM address.
REQ-015 RAM write is synchronous: on d_w=1 at a mapped, aligned RAM address, mem[daddr[31:2]] <= ddata_w at the clock edge.
REQ-016 ddata_r is 0 when d_r=0, or the address is unmapped, or the access is misaligned.
REQ-017 Unmapped or misaligned accesses (d_r or d_w) change no state except setting the sticky ERR flag next cycle.
REQ-018 If d_r and d_w are both 1 in one cycle, the write is performed and ddata_r returns the pre-write value.
REQ-019 GPIO: a write stores ddata_w[7:0]; a read returns {24'b0, gpio}.
REQ-020 CYCLE is a 32-bit counter that increments every cycle and wraps 0xFFFFFFFF -> 0.
REQ-021 A write to CYCLE loads it with 0, taking priority over that cycle's increment.
REQ-022 STATUS read returns {28'b0, ERR, busy, empty, full}, where busy = (UART state != IDLE).
REQ-023 TX FIFO: 4 entries of 8 bits, first in first out; count range 0..4; full = (count==4); empty = (count==0).
REQ-024 A TXDATA write pushes ddata_w[7:0].
REQ-025 A push while full (full sampled at the start of that cycle) is dropped and sets ERR, even if a pop occurs in the same cycle.
REQ-026 A simultaneous push and pop with the FIFO neither full nor empty leaves count unchanged; order is preserved.
REQ-027 UART FSM states: IDLE, START, DATA, STOP.
- IDLE: tx_o=1. If the FIFO is not empty, pop the head byte into the shift register and go to START next cycle.
- START: tx_o=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: send 8 bits LSB first, each held CLKS_PER_BIT cycles (tracked by a bit counter 0..7), then go to STOP.
- STOP: tx_o=1 for CLKS_PER_BIT cycles, then go to IDLE.
REQ-028 A full frame lasts 10*CLKS_PER_BIT cycles, with one IDLE cycle between back-to-back frames.
REQ-029 The baud counter runs 0..CLKS_PER_BIT-1 and resets on every state change.
REQ-030 ERR is sticky: it is set by the REQ-017 and REQ-025 events and cleared by a write to STATUS; if set and clear coincide, set wins.

Reset
REQ-031 On reset=1 at a clock edge, the following are cleared: gpio=0, CYCLE=0, FIFO count=0, ERR=0, UART state=IDLE, baud and bit counters=0.
REQ-032 During and after reset, tx_o=1 and gpio_out=0.
REQ-033 RAM contents are not affected by reset.
REQ-034 A reset in the middle of a frame aborts it, and tx_o returns to 1 on the next cycle.
REQ-035 Reset has priority over every simultaneous access.

Verification
REQ-036 Store 0xDEADBEEF at 0x10, then load 0x10 -> ddata_r=0xDEADBEEF in the load cycle; load 0x12 -> ddata_r=0 and STATUS bit3=1.
REQ-037 Write 0x1A5 to 0xFFFF0000 -> gpio_out=0xA5; read 0xFFFF0000 -> 0x000000A5.
REQ-038 Release reset, then read CYCLE after exactly N edges -> N. Write CYCLE -> the next read equals the cycles elapsed since that write. Preload 0xFFFFFFFF -> next value is 0.
REQ-039 CLKS_PER_BIT=4; push 0x55 -> tx_o reads 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles; busy=1 for 40 cycles.
REQ-040 Push 6 bytes in consecutive cycles while idle -> the 1st byte is popped on its first cycle, 4 are queued, the 6th is dropped, full=1, ERR=1; 5 frames are transmitted in order.
REQ-041 Assert reset during the DATA state -> tx_o=1 the next cycle, STATUS=0x2, and RAM data is intact.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: word RAM plus GPIO, cycle counter, status and a FIFO-fed UART transmitter
module data_mem_responder #(
  parameter int DEPTH_WORDS  = 1024,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] ddata_w,
  input  logic        d_w,
  input  logic        d_r,
  output logic [31:0] ddata_r,
  output logic [7:0]  gpio_out,
  output logic        tx_o
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic [31:0] mem [DEPTH_WORDS];
  logic [7:0]  fifo [4];
  logic [7:0]  gpio, shreg, shreg_n;
  logic [31:0] cycle;
  logic [1:0]  rd_ptr, wr_ptr;
  logic [2:0]  count, bitc, bitc_n;
  logic [BW-1:0] baud, baud_n;
  state_t      state, state_n;
  logic err, aligned, is_ram, is_gpio, is_cycle, is_tx, is_status, ok;
  logic full, empty, busy, push, pop, err_set, tick;
  logic [AW-1:0] idx;
  assign idx       = daddr[AW+1:2];
  assign aligned   = daddr[1:0] == 2'b00;
  assign is_ram    = daddr < RAM_BYTES;
  assign is_gpio   = daddr == 32'hFFFF_0000;
  assign is_cycle  = daddr == 32'hFFFF_0004;
  assign is_tx     = daddr == 32'hFFFF_0008;
  assign is_status = daddr == 32'hFFFF_000C;
  assign ok        = aligned & (is_ram | is_gpio | is_cycle | is_tx | is_status);
  assign full      = count == 3'd4;
  assign empty     = count == 3'd0;
  assign busy      = state != IDLE;
  assign pop       = (state == IDLE) & ~empty;
  assign push      = d_w & ok & is_tx & ~full;
  // full is the start-of-cycle value, so a push into a full FIFO is lost even if the UART pops now
  assign err_set   = ((d_r | d_w) & ~ok) | (d_w & ok & is_tx & full);
  assign ddata_r   = ~(d_r & ok) ? '0 :
                     is_ram    ? mem[idx] :
                     is_gpio   ? {24'b0, gpio} :
                     is_cycle  ? cycle :
                     is_status ? {28'b0, err, busy, empty, full} : '0;
  assign gpio_out  = gpio;
  assign tx_o      = state == START ? 1'b0 : state == DATA ? shreg[0] : 1'b1;
  always_ff @(posedge clk) begin
    if (!reset && d_w && ok && is_ram) mem[idx] <= ddata_w;
    if (!reset && push) fifo[wr_ptr] <= ddata_w[7:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      gpio   <= '0;
      cycle  <= '0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      err    <= 1'b0;
    end else begin
      cycle  <= (d_w & ok & is_cycle) ? 32'd0 : cycle + 32'd1;
      if (d_w && ok && is_gpio) gpio <= ddata_w[7:0];
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count  <= count + {2'b0, push} - {2'b0, pop};
      err    <= err_set | (err & ~(d_w & ok & is_status));
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      baud  <= '0;
      bitc  <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      baud  <= baud_n;
      bitc  <= bitc_n;
      shreg <= shreg_n;
    end
  end
  always_comb begin
    state_n = state;
    baud_n  = baud + 1'b1;
    bitc_n  = bitc;
    shreg_n = shreg;
    tick    = baud == BAUD_MAX;
    case (state)
      IDLE: begin
        baud_n = '0;
        if (!empty) begin
          state_n = START;
          shreg_n = fifo[rd_ptr];
        end
      end
      START: if (tick) begin
        state_n = DATA;
        baud_n  = '0;
        bitc_n  = '0;
      end
      DATA: if (tick) begin
        baud_n  = '0;
        shreg_n = shreg >> 1;
        bitc_n  = bitc + 3'd1;
        if (bitc == 3'd7) state_n = STOP;
      end
      STOP: if (tick) begin
        state_n = IDLE;
        baud_n  = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed stimulus checked every cycle against a behavioural model plus literal expectations
module tb_data_mem_responder;
  localparam int CPB = 4;
  localparam int DW  = 64;
  localparam logic [31:0] GPIO = 32'hFFFF_0000, CYC = 32'hFFFF_0004, TXD = 32'hFFFF_0008, STS = 32'hFFFF_000C;
  logic clk = 0, reset = 1, d_w = 0, d_r = 0, tx_o;
  logic [31:0] daddr = 0, ddata_w = 0, ddata_r;
  logic [7:0] gpio_out;
  int n_cmp = 0, n_fail = 0;
  data_mem_responder #(.DEPTH_WORDS(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .daddr(daddr), .ddata_w(ddata_w), .d_w(d_w), .d_r(d_r),
    .ddata_r(ddata_r), .gpio_out(gpio_out), .tx_o(tx_o));
  always #5 clk = ~clk;
  logic [31:0] m_mem [DW];
  logic [7:0]  m_gpio, m_byte;
  logic [31:0] m_cycle;
  logic [7:0]  q [$];
  bit m_err, m_valid = 0;
  int m_t = -1;
  function automatic int kind(logic [31:0] a);
    if (a[1:0] != 2'b00) return 0;
    if (a < 32'(DW * 4)) return 1;
    case (a)
      GPIO: return 2;
      CYC:  return 3;
      TXD:  return 4;
      STS:  return 5;
      default: return 0;
    endcase
  endfunction
  function automatic logic [31:0] m_status();
    return {28'b0, m_err, m_t >= 0, q.size() == 0, q.size() == 4};
  endfunction
  // a frame is 10 slots of CPB cycles: start 0, eight data bits LSB first, stop 1
  function automatic logic m_tx();
    if (m_t < 0 || m_t >= 9 * CPB) return 1'b1;
    if (m_t < CPB) return 1'b0;
    return m_byte[m_t / CPB - 1];
  endfunction
  function automatic logic [31:0] exp_rd();
    if (!d_r) return 0;
    case (kind(daddr))
      1: return m_mem[daddr[7:2]];
      2: return {24'b0, m_gpio};
      3: return m_cycle;
      5: return m_status();
      default: return 0;
    endcase
  endfunction
  always @(posedge clk) begin : model
    int k;
    bit fullb, pop, set, clr;
    if (reset) begin
      m_gpio = 0; m_cycle = 0; q.delete(); m_err = 0; m_t = -1; m_valid = 1;
    end else begin
      k = kind(daddr);
      fullb = q.size() == 4;
      pop = m_t < 0 && q.size() > 0;
      set = ((d_r || d_w) && k == 0) || (d_w && k == 4 && fullb);
      clr = d_w && k == 5;
      m_cycle = (d_w && k == 3) ? 32'd0 : m_cycle + 32'd1;
      if (d_w && k == 1) m_mem[daddr[7:2]] = ddata_w;
      if (d_w && k == 2) m_gpio = ddata_w[7:0];
      if (m_t >= 0) m_t = (m_t == 10 * CPB - 1) ? -1 : m_t + 1;
      else if (pop) begin m_byte = q.pop_front(); m_t = 0; end
      if (d_w && k == 4 && !fullb) q.push_back(ddata_w[7:0]);
      if (clr) m_err = 0;
      if (set) m_err = 1;
    end
  end
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (m_valid) begin
    chk("model ddata_r", ddata_r, exp_rd());
    chk("model gpio_out", 32'(gpio_out), 32'(m_gpio));
    chk("model tx_o", 32'(tx_o), 32'(m_tx()));
  end
  task automatic drive(bit r, bit w, logic [31:0] a, logic [31:0] d);
    @(posedge clk); #1;
    d_r = r; d_w = w; daddr = a; ddata_w = d;
    @(negedge clk);
  endtask
  task automatic idle(int n);
    repeat (n) drive(0, 0, 0, 0);
  endtask
  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1);
  end
  initial begin
    logic [9:0] pat;
    pat = 10'b1010101010;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("reset tx_o", 32'(tx_o), 1);
    chk("reset gpio_out", 32'(gpio_out), 0);
    idle(4);
    drive(1, 0, CYC, 0);        chk("cycle after 5 edges", ddata_r, 5);
    drive(1, 0, STS, 0);        chk("status after reset", ddata_r, 32'h2);
    drive(0, 1, 32'h10, 32'hDEADBEEF);
    drive(1, 0, 32'h10, 0);     chk("ram load", ddata_r, 32'hDEADBEEF);
    drive(1, 0, 32'h12, 0);     chk("misaligned load", ddata_r, 0);
    drive(1, 0, STS, 0);        chk("status err", ddata_r, 32'hA);
    drive(0, 1, STS, 0);
    drive(1, 0, STS, 0);        chk("status err cleared", ddata_r, 32'h2);
    drive(1, 1, 32'h10, 32'h12345678); chk("read-during-write old", ddata_r, 32'hDEADBEEF);
    drive(1, 0, 32'h10, 0);     chk("read-during-write new", ddata_r, 32'h12345678);
    drive(0, 1, 32'h0, 32'h11111111);
    drive(0, 1, 32'hFC, 32'hCAFEF00D);
    drive(0, 1, 32'h100, 32'h22222222);
    drive(1, 0, 32'hFC, 0);     chk("last ram word", ddata_r, 32'hCAFEF00D);
    drive(1, 0, 32'h0, 0);      chk("no alias from unmapped", ddata_r, 32'h11111111);
    drive(1, 0, 32'h100, 0);    chk("unmapped load", ddata_r, 0);
    drive(1, 0, STS, 0);        chk("status unmapped err", ddata_r, 32'hA);
    drive(0, 1, STS, 0);
    drive(0, 1, GPIO, 32'h1A5);
    drive(1, 0, GPIO, 0);       chk("gpio read", ddata_r, 32'hA5);
                                chk("gpio_out", 32'(gpio_out), 32'hA5);
    drive(1, 0, TXD, 0);        chk("txdata read", ddata_r, 0);
    drive(0, 1, CYC, 0);
    idle(3);
    drive(1, 0, CYC, 0);        chk("cycle since write", ddata_r, 3);
    drive(0, 1, TXD, 32'h55);
    drive(1, 0, STS, 0);        chk("status queued", ddata_r, 0);
    for (int i = 0; i < 40; i++) begin
      drive(1, 0, STS, 0);
      chk("uart bit", 32'(tx_o), 32'(pat[i / CPB]));
      chk("uart busy", ddata_r, 32'h6);
    end
    drive(1, 0, STS, 0);        chk("uart done", ddata_r, 32'h2);
    for (int i = 0; i < 6; i++) drive(0, 1, TXD, 32'(160 + i));
    drive(1, 0, STS, 0);        chk("burst full err", ddata_r, 32'hD);
    idle(5 * 41 + 5);
    drive(1, 0, STS, 0);        chk("burst drained", ddata_r, 32'hA);
    drive(0, 1, STS, 0);
    drive(0, 1, TXD, 0);
    idle(8);                    chk("mid-frame tx low", 32'(tx_o), 0);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("abort tx_o", 32'(tx_o), 1);
    chk("abort gpio_out", 32'(gpio_out), 0);
    drive(1, 0, STS, 0);        chk("abort status", ddata_r, 32'h2);
    drive(1, 0, 32'h10, 0);     chk("ram kept over reset", ddata_r, 32'h12345678);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
